motor_pwm_driver: RTL and testbench

Motor-side counterpart of the operator interface FSM. It consumes the interface's run, increase and decrease command levels, holds a duty level of 0..9, and generates the real PWM waveform for the motor power stage. It also drives an active-low 7-segment digit showing the current duty level. It sits between the operator interface block and the motor output pin.

---
 rtl/motor_pwm_driver_pkg.sv | 58 +++++
 rtl/motor_pwm_driver_if.sv | 36 +++
 rtl/motor_pwm_driver_seg7.sv | 33 +++
 rtl/motor_pwm_driver.sv | 204 ++++++++++++++++++++
 tb/tb_motor_pwm_driver.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_pwm_driver_pkg.sv
// ---------------------------------------------------------------------------
// motor_pkg
// Shared types and constants for the motor PWM driver slice.
//   - motor_state_e : driver FSM states (STOPPED, RUN, RAMP)
//   - LEVEL_W       : width of the duty level (0..9 fits in 4 bits)
//   - SEG_*         : active-low 7-segment codes, gfedcba bit order
//   - level_step    : saturating +/-1 helper for the duty level
// ---------------------------------------------------------------------------
package motor_pkg;

    localparam int LEVEL_W = 4;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        RAMP    = 2'd2
    } motor_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Saturating single step: up wins only when dn is clear and vice versa.
    function automatic logic [LEVEL_W-1:0] level_step(
        input logic [LEVEL_W-1:0] lvl,
        input logic               up,
        input logic               dn,
        input logic [LEVEL_W-1:0] lmax
    );
        logic [LEVEL_W-1:0] res;
        res = lvl;
        if (up && !dn) begin
            if (lvl < lmax) begin
                res = lvl + LEVEL_W'(1);
            end else begin
                res = lmax;
            end
        end else if (dn && !up) begin
            if (lvl != {LEVEL_W{1'b0}}) begin
                res = lvl - LEVEL_W'(1);
            end else begin
                res = {LEVEL_W{1'b0}};
            end
        end else begin
            res = lvl;
        end
        return res;
    endfunction

endpackage

// File: rtl/motor_pwm_driver_if.sv
// ---------------------------------------------------------------------------
// motor_pwm_driver_if
// Bundles the operator-side commands and motor-side outputs of the driver.
//   master : operator interface side (drives commands, observes outputs)
//   slave  : motor_pwm_driver side
// Signals:
//   motor_running  run command (1 = run)
//   swt_increase   increase request level
//   swt_decrease   decrease request level
//   pwm_out        registered PWM drive to the motor
//   duty_level     current target level 0..LEVEL_MAX
//   active         1 while the driver FSM is not STOPPED
//   display        active-low 7-segment code of duty_level (gfedcba)
// ---------------------------------------------------------------------------
interface motor_pwm_driver_if;
    import motor_pkg::*;

    logic               motor_running;
    logic               swt_increase;
    logic               swt_decrease;
    logic               pwm_out;
    logic [LEVEL_W-1:0] duty_level;
    logic               active;
    logic [6:0]         display;

    modport master (
        output motor_running, swt_increase, swt_decrease,
        input  pwm_out, duty_level, active, display
    );

    modport slave (
        input  motor_running, swt_increase, swt_decrease,
        output pwm_out, duty_level, active, display
    );

endinterface

// File: rtl/motor_pwm_driver_seg7.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Converts a 4-bit value into an active-low 7-segment code (gfedcba).
// Values above 9 blank the digit.
//   value : 4-bit input value
//   seg   : active-low segment code
// ---------------------------------------------------------------------------
module seg7_decoder
    import motor_pkg::*;
(
    input  logic [LEVEL_W-1:0] value,
    output logic [6:0]         seg
);

    // Digit lookup, blank for anything outside 0..9.
    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// ---------------------------------------------------------------------------
// motor_pwm_driver
// Motor-side counterpart of the operator interface FSM. Holds a duty level
// 0..LEVEL_MAX driven by edge-detected increase/decrease requests and turns
// it into a PWM waveform of period LEVEL_MAX*STEP_CYCLES. The applied duty
// only changes at period boundaries (and at start), so a period is never cut.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   motor_pwm_driver_if.slave (commands in, pwm/level/display out)
//
// Parameters:
//   STEP_CYCLES  clock cycles per duty step
//   LEVEL_MAX    highest duty level (100 % duty), at most 9
//   LEVEL_START  level loaded when the motor starts, at most LEVEL_MAX
//
// Build option:
//   SOFT_START_EN  when defined, starting enters a RAMP state that climbs
//                  from level 1 to LEVEL_START one step per completed period
//                  while ignoring increase/decrease requests.
// ---------------------------------------------------------------------------
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int STEP_CYCLES = 100,
    parameter int LEVEL_MAX   = 9,
    parameter int LEVEL_START = 5
)
(
    input  logic          clk,
    input  logic          rst,
    motor_pwm_driver_if.slave bus
);

    localparam int PERIOD = LEVEL_MAX * STEP_CYCLES;
    // +1 so a compare equal to the full period still fits (constant-high duty).
    localparam int CNT_W  = $clog2(PERIOD + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [LEVEL_W-1:0] LVL_ZERO  = {LEVEL_W{1'b0}};
    localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LVL_START = LEVEL_W'(LEVEL_START);

`ifdef SOFT_START_EN
    // A start level of 0 or 1 has nothing to ramp through.
    localparam bit           USE_RAMP    = (LEVEL_START > 1);
    localparam motor_state_e ENTRY_STATE = USE_RAMP ? RAMP : RUN;
    localparam logic [LEVEL_W-1:0] LVL_ENTRY = USE_RAMP ? LEVEL_W'(1) : LVL_START;
`else
    localparam motor_state_e ENTRY_STATE = RUN;
    localparam logic [LEVEL_W-1:0] LVL_ENTRY = LVL_START;
`endif

    function automatic logic [CNT_W-1:0] level_to_cmp(input logic [LEVEL_W-1:0] lvl);
        return CNT_W'(lvl) * CNT_W'(STEP_CYCLES);
    endfunction

    motor_state_e       state_r;
    motor_state_e       state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [CNT_W-1:0]   cmp_r;
    logic [CNT_W-1:0]   cmp_nxt_s;
    logic [LEVEL_W-1:0] level_r;
    logic [LEVEL_W-1:0] level_nxt_s;
    logic               load_cmp_s;
    logic               pwm_r;
    logic               pwm_nxt_s;
    logic               hist_inc_r;
    logic               hist_dec_r;
    logic               inc_evt_s;
    logic               dec_evt_s;
    logic               wrap_s;

    assign inc_evt_s = bus.swt_increase & ~hist_inc_r;
    assign dec_evt_s = bus.swt_decrease & ~hist_dec_r;
    assign wrap_s    = (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= STOPPED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a dropped run command stops immediately from any state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            STOPPED: begin
                if (bus.motor_running) begin
                    state_nxt_s = ENTRY_STATE;
                end else begin
                    state_nxt_s = STOPPED;
                end
            end
            RUN: begin
                if (!bus.motor_running) begin
                    state_nxt_s = STOPPED;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            RAMP: begin
                if (!bus.motor_running) begin
                    state_nxt_s = STOPPED;
                end else if (wrap_s && ((level_r + LEVEL_W'(1)) >= LVL_START)) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = RAMP;
                end
            end
            default: begin
                state_nxt_s = STOPPED;
            end
        endcase
    end

    // Next counter, level, compare and PWM values.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        load_cmp_s  = 1'b0;
        case (state_r)
            STOPPED: begin
                cnt_nxt_s = CNT_ZERO;
                if (bus.motor_running) begin
                    level_nxt_s = LVL_ENTRY;
                    load_cmp_s  = 1'b1;
                end else begin
                    level_nxt_s = LVL_ZERO;
                end
            end
            RUN: begin
                if (!bus.motor_running) begin
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = LVL_ZERO;
                end else begin
                    cnt_nxt_s   = wrap_s ? CNT_ZERO : cnt_r + CNT_W'(1);
                    level_nxt_s = level_step(level_r, inc_evt_s, dec_evt_s, LVL_MAX);
                    load_cmp_s  = wrap_s;
                end
            end
            RAMP: begin
                if (!bus.motor_running) begin
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = LVL_ZERO;
                end else begin
                    cnt_nxt_s   = wrap_s ? CNT_ZERO : cnt_r + CNT_W'(1);
                    level_nxt_s = wrap_s ? level_r + LEVEL_W'(1) : level_r;
                    load_cmp_s  = wrap_s;
                end
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                level_nxt_s = LVL_ZERO;
            end
        endcase

        // The compare follows the level that will be live in the new period.
        if (load_cmp_s) begin
            cmp_nxt_s = level_to_cmp(level_nxt_s);
        end else if (state_nxt_s == STOPPED) begin
            cmp_nxt_s = CNT_ZERO;
        end else begin
            cmp_nxt_s = cmp_r;
        end

        pwm_nxt_s = (state_nxt_s != STOPPED) && (cnt_nxt_s < cmp_nxt_s);
    end

    // Datapath registers and switch history.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= CNT_ZERO;
            cmp_r      <= CNT_ZERO;
            level_r    <= LVL_ZERO;
            pwm_r      <= 1'b0;
            hist_inc_r <= 1'b0;
            hist_dec_r <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            cmp_r      <= cmp_nxt_s;
            level_r    <= level_nxt_s;
            pwm_r      <= pwm_nxt_s;
            hist_inc_r <= bus.swt_increase;
            hist_dec_r <= bus.swt_decrease;
        end
    end

    assign bus.pwm_out    = pwm_r;
    assign bus.duty_level = level_r;
    assign bus.active     = (state_r != STOPPED);

    seg7_decoder u_seg7 (
        .value (level_r),
        .seg   (bus.display)
    );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_motor_pwm_driver
// Self-checking bench for motor_pwm_driver with STEP_CYCLES=4 (period 36).
// A behavioural model tracks run/stop, the duty level, the position inside
// the current PWM period and the level applied to that period; the expected
// PWM is "running and position < applied*STEP".
// Build with +define+SOFT_START_EN to exercise the ramp start.
// ---------------------------------------------------------------------------
module tb_motor_pwm_driver;
    import motor_pkg::*;

    localparam int STEP   = 4;
    localparam int LMAX   = 9;
    localparam int LSTART = 5;
    localparam int PERIOD = LMAX * STEP;
`ifdef SOFT_START_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    motor_pwm_driver_if bif ();

    motor_pwm_driver #(
        .STEP_CYCLES (STEP),
        .LEVEL_MAX   (LMAX),
        .LEVEL_START (LSTART)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    // Reference model state
    bit m_run, m_ramp, m_hinc, m_hdec;
    int m_level, m_applied, m_pos;

    function automatic logic exp_pwm();
        return m_run && (m_pos < m_applied * STEP);
    endfunction

    task automatic model_edge();
        bit ie, de, wrap;
        if (rst) begin
            m_run = 0; m_ramp = 0; m_level = 0; m_applied = 0; m_pos = 0;
            m_hinc = 0; m_hdec = 0;
        end else begin
            ie = bif.swt_increase && !m_hinc;
            de = bif.swt_decrease && !m_hdec;
            if (!m_run) begin
                if (bif.motor_running) begin
                    m_run     = 1;
                    m_ramp    = SOFT && (LSTART > 1);
                    m_level   = m_ramp ? 1 : LSTART;
                    m_pos     = 0;
                    m_applied = m_level;
                end
            end else if (!bif.motor_running) begin
                m_run = 0; m_ramp = 0; m_level = 0; m_applied = 0; m_pos = 0;
            end else begin
                wrap  = (m_pos == PERIOD - 1);
                m_pos = (m_pos + 1) % PERIOD;
                if (m_ramp) begin
                    if (wrap) begin
                        m_level++;
                        if (m_level == LSTART) m_ramp = 0;
                    end
                end else if (ie && !de) begin
                    m_level = (m_level < LMAX) ? m_level + 1 : LMAX;
                end else if (de && !ie) begin
                    m_level = (m_level > 0) ? m_level - 1 : 0;
                end
                if (wrap) m_applied = m_level;
            end
            m_hinc = bif.swt_increase;
            m_hdec = bif.swt_decrease;
        end
    endtask

    // One clock: model follows the edge, outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.motor_running = 1'b0;
        bif.swt_increase  = 1'b0;
        bif.swt_decrease  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_total++; if (bif.pwm_out !== 1'b0) $display("FAIL reset_pwm got=%b exp=0", bif.pwm_out); else n_pass++;
        n_total++; if (bif.duty_level !== 4'd0) $display("FAIL reset_duty got=%0d exp=0", bif.duty_level); else n_pass++;
        n_total++; if (bif.active !== 1'b0) $display("FAIL reset_active got=%b exp=0", bif.active); else n_pass++;
        n_total++; if (bif.display !== 7'b1000000) $display("FAIL reset_display got=%b exp=1000000", bif.display); else n_pass++;
        // Requests while stopped are discarded.
        bif.swt_increase = 1'b1;
        tick();
        bif.swt_increase = 1'b0;
        tick();
        n_total++; if (bif.duty_level !== 4'd0 || bif.active !== 1'b0)
            $display("FAIL stopped_ignores_inc got duty=%0d active=%b exp duty=0 active=0", bif.duty_level, bif.active);
        else n_pass++;
    endtask

    task automatic test_start();
        int hi;
        // Switch already high at start must not count as an event.
        bif.swt_increase  = 1'b1;
        bif.motor_running = 1'b1;
        tick();
        n_total++; if (bif.duty_level !== 4'(SOFT ? 1 : LSTART))
            $display("FAIL start_duty got=%0d exp=%0d", bif.duty_level, SOFT ? 1 : LSTART);
        else n_pass++;
        n_total++; if (bif.active !== 1'b1) $display("FAIL start_active got=%b exp=1", bif.active); else n_pass++;
`ifdef SOFT_START_EN
        n_total++; if (bif.display !== 7'b1111001) $display("FAIL start_display got=%b exp=1111001", bif.display); else n_pass++;
        bif.swt_increase = 1'b0;
        for (int p = 0; p < LSTART - 1; p++) begin
            n_total++; if (bif.duty_level !== 4'(p + 1))
                $display("FAIL ramp_level period=%0d got=%0d exp=%0d", p, bif.duty_level, p + 1);
            else n_pass++;
            for (int i = 0; i < PERIOD; i++) begin
                if (i == 10) bif.swt_increase = 1'b1;
                if (i == 11) bif.swt_increase = 1'b0;
                n_total++; if (bif.pwm_out !== exp_pwm())
                    $display("FAIL ramp_pwm p=%0d i=%0d got=%b exp=%b", p, i, bif.pwm_out, exp_pwm());
                else n_pass++;
                tick();
            end
        end
`else
        n_total++; if (bif.display !== 7'b0010010) $display("FAIL start_display got=%b exp=0010010", bif.display); else n_pass++;
        tick();
        bif.swt_increase = 1'b0;
        for (int i = 1; i < PERIOD; i++) tick();
`endif
        n_total++; if (bif.duty_level !== 4'(LSTART))
            $display("FAIL run_level got=%0d exp=%0d", bif.duty_level, LSTART);
        else n_pass++;
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            hi += int'(bif.pwm_out);
            n_total++; if (bif.pwm_out !== exp_pwm())
                $display("FAIL start_pwm i=%0d got=%b exp=%b", i, bif.pwm_out, exp_pwm());
            else n_pass++;
            tick();
        end
        n_total++; if (hi !== 20) $display("FAIL start_high_time got=%0d exp=20", hi); else n_pass++;
    endtask

    task automatic test_increase();
        int hi;
        int exp_hi [3];
        int exp_lv [3];
        exp_hi[0] = 20; exp_hi[1] = 24; exp_hi[2] = 28;
        exp_lv[0] = 6;  exp_lv[1] = 7;  exp_lv[2] = 7;
        for (int p = 0; p < 3; p++) begin
            hi = 0;
            for (int i = 0; i < PERIOD; i++) begin
                if (p == 0 && i == 2)  bif.swt_increase = 1'b1;
                if (p == 0 && i == 3)  bif.swt_increase = 1'b0;
                if (p == 1 && i == 5)  bif.swt_increase = 1'b1;
                if (p == 1 && i == 15) bif.swt_increase = 1'b0;
                hi += int'(bif.pwm_out);
                n_total++; if (bif.pwm_out !== exp_pwm())
                    $display("FAIL inc_pwm p=%0d i=%0d got=%b exp=%b", p, i, bif.pwm_out, exp_pwm());
                else n_pass++;
                tick();
                if (p == 0 && i == 2) begin
                    n_total++; if (bif.duty_level !== 4'd6)
                        $display("FAIL inc_one_cycle got=%0d exp=6", bif.duty_level);
                    else n_pass++;
                end
            end
            n_total++; if (hi !== exp_hi[p]) $display("FAIL inc_high_time p=%0d got=%0d exp=%0d", p, hi, exp_hi[p]); else n_pass++;
            n_total++; if (bif.duty_level !== 4'(exp_lv[p])) $display("FAIL inc_level p=%0d got=%0d exp=%0d", p, bif.duty_level, exp_lv[p]); else n_pass++;
        end
    endtask

    task automatic run_to_boundary();
        for (int k = 0; k < PERIOD + 2 && m_pos != 0; k++) tick();
    endtask

    task automatic test_saturate();
        int hi;
        for (int k = 0; k < 12; k++) begin
            bif.swt_increase = 1'b1; tick();
            bif.swt_increase = 1'b0; tick();
        end
        n_total++; if (bif.duty_level !== 4'd9) $display("FAIL sat_high_level got=%0d exp=9", bif.duty_level); else n_pass++;
        n_total++; if (bif.display !== 7'b0010000) $display("FAIL sat_high_display got=%b exp=0010000", bif.display); else n_pass++;
        run_to_boundary();
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin hi += int'(bif.pwm_out); tick(); end
        n_total++; if (hi !== PERIOD) $display("FAIL sat_high_pwm got=%0d exp=%0d", hi, PERIOD); else n_pass++;
        for (int k = 0; k < 12; k++) begin
            bif.swt_decrease = 1'b1; tick();
            bif.swt_decrease = 1'b0; tick();
        end
        n_total++; if (bif.duty_level !== 4'd0) $display("FAIL sat_low_level got=%0d exp=0", bif.duty_level); else n_pass++;
        run_to_boundary();
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin hi += int'(bif.pwm_out); tick(); end
        n_total++; if (hi !== 0) $display("FAIL sat_low_pwm got=%0d exp=0", hi); else n_pass++;
        n_total++; if (bif.active !== 1'b1) $display("FAIL sat_low_active got=%b exp=1", bif.active); else n_pass++;
    endtask

    task automatic test_simultaneous();
        bif.swt_increase = 1'b1; tick();
        bif.swt_increase = 1'b0; tick();
        bif.swt_increase = 1'b1;
        bif.swt_decrease = 1'b1;
        tick();
        n_total++; if (bif.duty_level !== 4'd1) $display("FAIL simultaneous got=%0d exp=1", bif.duty_level); else n_pass++;
        bif.swt_increase = 1'b0;
        bif.swt_decrease = 1'b0;
        tick();
    endtask

    task automatic test_stop_midperiod();
        for (int k = 0; k < 7; k++) begin
            bif.swt_increase = 1'b1; tick();
            bif.swt_increase = 1'b0; tick();
        end
        run_to_boundary();
        for (int k = 0; k < 10; k++) tick();
        n_total++; if (bif.pwm_out !== 1'b1 || m_pos != 10)
            $display("FAIL stop_pre_pwm got=%b pos=%0d exp=1 pos=10", bif.pwm_out, m_pos);
        else n_pass++;
        bif.motor_running = 1'b0;
        tick();
        n_total++; if (bif.pwm_out !== 1'b0 || bif.duty_level !== 4'd0 || bif.active !== 1'b0)
            $display("FAIL stop_mid got pwm=%b duty=%0d active=%b exp 0/0/0", bif.pwm_out, bif.duty_level, bif.active);
        else n_pass++;
        bif.motor_running = 1'b1;
        tick();
        n_total++; if (bif.duty_level !== 4'(m_level) || bif.pwm_out !== 1'b1)
            $display("FAIL restart got duty=%0d pwm=%b exp duty=%0d pwm=1", bif.duty_level, bif.pwm_out, m_level);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        n_total++; if (bif.pwm_out !== 1'b0 || bif.duty_level !== 4'd0 || bif.active !== 1'b0 || bif.display !== 7'b1000000)
            $display("FAIL reset_midrun got pwm=%b duty=%0d active=%b disp=%b exp 0/0/0/1000000",
                     bif.pwm_out, bif.duty_level, bif.active, bif.display);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_total++; if (bif.active !== 1'b1 || bif.duty_level !== 4'(m_level))
            $display("FAIL after_reset_start got active=%b duty=%0d exp active=1 duty=%0d", bif.active, bif.duty_level, m_level);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 2500; c++) begin
            bif.swt_increase = ($urandom_range(0, 3) == 0);
            bif.swt_decrease = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) bif.motor_running = ~bif.motor_running;
            rst = ($urandom_range(0, 599) == 0);
            tick();
            n_total++; if (bif.pwm_out !== exp_pwm())
                $display("FAIL rand_pwm c=%0d got=%b exp=%b", c, bif.pwm_out, exp_pwm());
            else n_pass++;
            n_total++; if (bif.duty_level !== 4'(m_level) || bif.active !== m_run || bif.display !== seg_tab[m_level])
                $display("FAIL rand_state c=%0d got duty=%0d active=%b disp=%b exp duty=%0d active=%b disp=%b",
                         c, bif.duty_level, bif.active, bif.display, m_level, m_run, seg_tab[m_level]);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        bif.motor_running = 1'b0;
        bif.swt_increase  = 1'b0;
        bif.swt_decrease  = 1'b0;
        @(negedge clk);
        test_reset();
        test_start();
        test_increase();
        test_saturate();
        test_simultaneous();
        test_stop_midperiod();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
